capture_sequencer: RTL and testbench
====================================

// Module: capture_sequencer
// PURPOSE
// Host-side run controller for the logic-capture core: turns start/stop commands into arm/abort
// handshakes, tracks the core through armed/triggered/done, then waits for the downstream DMA to drain.
// Handles repeated (multi-shot) captures, a trigger-wait watchdog, overrun reporting and the
// completion interrupt. Lives in the clk domain; all capture status inputs are resynchronised here.
// PARAMETERS
// saddr_w     24  width of trigger position / sample address
// timeout_w   32  width of trigger-wait watchdog counter
// rep_w       8   width of repeat / completed-capture counters
// PORTS
// clk             in   1          system clock
// resetn          in   1          asynchronous active-low reset
// start           in   1          1-cycle pulse: begin run (ignored unless IDLE)
// stop            in   1          1-cycle pulse: abort run (any non-IDLE state)
// repeat_count    in   rep_w      captures per run; 0 = continuous until stop
// timeout         in   timeout_w  max clk cycles in ARMED before trigger; 0 = disabled
// cap_ready       in   1          capture core ready (async, sync'd here)
// cap_armed       in   1          capture core armed (async, sync'd here)
// cap_triggered   in   1          capture core triggered (async, sync'd here)
// cap_done        in   1          capture core done (async, sync'd here)
// cap_overrun     in   1          capture core overrun (async, sync'd here)
// cap_trig_pos    in   saddr_w    trigger position; stable while cap_done is high
// dma_idle        in   1          downstream stream/DMA has flushed all beats
// cap_arm         out  1          arm level to capture core
// cap_abort       out  1          abort level to capture core
// busy            out  1          state != IDLE
// state           out  3          current FSM encoding (for status register)
// done_count      out  rep_w      captures completed this run
// trig_pos        out  saddr_w    trigger position latched at last completion
// err_overrun     out  1          sticky: overrun seen during run
// err_timeout     out  1          sticky: watchdog expired
// irq             out  1          1-cycle pulse on run end (normal, stop or error)
// BEHAVIOUR
// - Reset (resetn=0, async): state=IDLE; all outputs 0; counters 0; sync flops 0.
// - Every cap_* status input passes through a 2-flop synchronizer => 2 clk latency; cap_trig_pos is not
//   synchronised, sampled only on the cycle the synchronised done first reads 1 (done_s rising).
// - States (enc): IDLE 0, WAIT_RDY 1, ARMING 2, ARMED 3, TRIGGERED 4, DRAIN 5, ABORTING 6.
// - IDLE: start -> clear done_count, err_*; -> WAIT_RDY. start+stop same cycle: stop wins, stay IDLE.
// - WAIT_RDY: ready_s=1 -> ARMING.
// - ARMING: cap_arm=1 (held) until armed_s=1 -> ARMED, cap_arm drops next cycle. Arm is a level because
//   the core samples on a slower clock and only arms when not mid-capture.
// - ARMED: watchdog counts up from 0; triggered_s=1 -> TRIGGERED. If timeout!=0 and count reaches
//   timeout-1 without trigger -> err_timeout=1, -> ABORTING. Trigger and expiry in same cycle: trigger wins.
// - TRIGGERED: done_s rising -> latch trig_pos, done_count+1 (wraps at 2^rep_w), -> DRAIN.
// - DRAIN: wait dma_idle=1. Then if repeat_count!=0 and done_count==repeat_count -> irq, IDLE;
//   else -> WAIT_RDY (next shot; done_count wrap allowed in continuous mode).
// - overrun_s=1 in ARMED/TRIGGERED: err_overrun=1 (sticky), -> ABORTING.
// - stop in any non-IDLE state (overrides same-cycle transitions) -> ABORTING.
// - ABORTING: cap_abort=1, cap_arm=0; wait armed_s=0 and triggered_s=0, plus dma_idle=1;
//   then cap_abort=0, irq pulse, -> IDLE. err_* flags hold until next start.
// - irq is asserted for exactly one cycle on the transition into IDLE from DRAIN or ABORTING.
// - cap_arm and cap_abort never both 1. All outputs registered.
// TESTING
// - Single shot: repeat_count=1, ready/armed/triggered/done toggled -> cap_arm held until armed_s,
//   trig_pos=0x000123 latched, done_count=1, one irq, state back to 0.
// - Multi-shot: repeat_count=3 -> three arm sequences, done_count 1,2,3, single irq after third DRAIN.
// - Watchdog: timeout=100, no trigger -> err_timeout at ARMED cycle 100, cap_abort until armed low, irq.
// - Overrun: cap_overrun pulse while TRIGGERED -> err_overrun=1, ABORTING, no done_count increment.
// - Stop mid-DRAIN with dma_idle=0 -> ABORTING, stays until dma_idle=1, then IDLE with irq.
// - Async reset asserted in ARMED -> all outputs 0 immediately; start+stop same cycle in IDLE -> no run.

Source files
------------

// File: rtl/capture_sequencer.sv
// capture_sequencer: host-side run controller sequencing arm/trigger/done/drain of the logic-capture core
module capture_sequencer #(
    parameter int saddr_w   = 24,
    parameter int timeout_w = 32,
    parameter int rep_w     = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 stop,
    input  logic [rep_w-1:0]     repeat_count,
    input  logic [timeout_w-1:0] timeout,
    input  logic                 cap_ready,
    input  logic                 cap_armed,
    input  logic                 cap_triggered,
    input  logic                 cap_done,
    input  logic                 cap_overrun,
    input  logic [saddr_w-1:0]   cap_trig_pos,
    input  logic                 dma_idle,
    output logic                 cap_arm,
    output logic                 cap_abort,
    output logic                 busy,
    output logic [2:0]           state,
    output logic [rep_w-1:0]     done_count,
    output logic [saddr_w-1:0]   trig_pos,
    output logic                 err_overrun,
    output logic                 err_timeout,
    output logic                 irq
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_RDY  = 3'd1,
        ARMING    = 3'd2,
        ARMED     = 3'd3,
        TRIGGERED = 3'd4,
        DRAIN     = 3'd5,
        ABORTING  = 3'd6
    } st_t;
    st_t st, nxt;
    logic [4:0] sync1, sync2;
    logic done_d;
    logic [timeout_w-1:0] wd;
    logic ready_s, armed_s, triggered_s, done_s, overrun_s;
    logic done_rise, wd_exp, last_shot, shot_done;
    assign {overrun_s, done_s, triggered_s, armed_s, ready_s} = sync2;
    assign done_rise = done_s & ~done_d;
    assign wd_exp    = (timeout != '0) && (wd == timeout - timeout_w'(1));
    assign last_shot = (repeat_count != '0) && (done_count == repeat_count);
    assign shot_done = (st == TRIGGERED) && (nxt == DRAIN);
    assign state     = st;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1  <= '0;
            sync2  <= '0;
            done_d <= 1'b0;
        end else begin
            sync1  <= {cap_overrun, cap_done, cap_triggered, cap_armed, cap_ready};
            sync2  <= sync1;
            done_d <= done_s;
        end
    end
    // stop overrides every transition decided below it
    always_comb begin
        nxt = st;
        case (st)
            IDLE:      nxt = (start && !stop) ? WAIT_RDY : IDLE;
            WAIT_RDY:  nxt = ready_s ? ARMING : WAIT_RDY;
            ARMING:    nxt = armed_s ? ARMED : ARMING;
            ARMED:     nxt = overrun_s ? ABORTING : triggered_s ? TRIGGERED : wd_exp ? ABORTING : ARMED;
            TRIGGERED: nxt = overrun_s ? ABORTING : done_rise ? DRAIN : TRIGGERED;
            DRAIN:     nxt = !dma_idle ? DRAIN : last_shot ? IDLE : WAIT_RDY;
            ABORTING:  nxt = (!armed_s && !triggered_s && dma_idle) ? IDLE : ABORTING;
            default:   nxt = IDLE;
        endcase
        if (stop && st != IDLE)
            nxt = ABORTING;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st          <= IDLE;
            wd          <= '0;
            cap_arm     <= 1'b0;
            cap_abort   <= 1'b0;
            busy        <= 1'b0;
            irq         <= 1'b0;
            done_count  <= '0;
            trig_pos    <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            st        <= nxt;
            wd        <= (st == ARMED) ? wd + timeout_w'(1) : '0;
            cap_arm   <= nxt == ARMING;
            cap_abort <= nxt == ABORTING;
            busy      <= nxt != IDLE;
            irq       <= (st == DRAIN || st == ABORTING) && nxt == IDLE;
            if (st == IDLE && nxt == WAIT_RDY) begin
                done_count  <= '0;
                err_overrun <= 1'b0;
                err_timeout <= 1'b0;
            end
            if (shot_done) begin
                done_count <= done_count + rep_w'(1);
                trig_pos   <= cap_trig_pos;
            end
            if ((st == ARMED || st == TRIGGERED) && overrun_s)
                err_overrun <= 1'b1;
            if (st == ARMED && !triggered_s && !overrun_s && wd_exp)
                err_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed checks of run sequencing, multi-shot, watchdog, overrun, stop and reset
module tb_capture_sequencer;
    localparam logic [2:0] S_IDLE = 3'd0, S_WRDY = 3'd1, S_ARMING = 3'd2, S_ARMED = 3'd3,
                           S_TRIG = 3'd4, S_DRAIN = 3'd5, S_ABORT = 3'd6;
    logic clk, resetn, start, stop, cap_ready, cap_armed, cap_triggered, cap_done, cap_overrun, dma_idle;
    logic [7:0] repeat_count;
    logic [31:0] timeout;
    logic [23:0] cap_trig_pos;
    logic cap_arm, cap_abort, busy, err_overrun, err_timeout, irq;
    logic [2:0] state;
    logic [7:0] done_count;
    logic [23:0] trig_pos;
    int n_cmp = 0, n_err = 0, irq_cnt = 0, excl_cnt = 0, irq_base;

    capture_sequencer dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .repeat_count(repeat_count),
        .timeout(timeout), .cap_ready(cap_ready), .cap_armed(cap_armed), .cap_triggered(cap_triggered),
        .cap_done(cap_done), .cap_overrun(cap_overrun), .cap_trig_pos(cap_trig_pos), .dma_idle(dma_idle),
        .cap_arm(cap_arm), .cap_abort(cap_abort), .busy(busy), .state(state), .done_count(done_count),
        .trig_pos(trig_pos), .err_overrun(err_overrun), .err_timeout(err_timeout), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) if (irq) irq_cnt++;
    always @(negedge clk) if (cap_arm && cap_abort) excl_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_st(input logic [2:0] s, input int budget, input string tag);
        int i = 0;
        while (state !== s && i < budget) begin
            tick();
            i++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic to_armed(input string tag);
        cap_ready = 1'b1;
        wait_st(S_ARMING, 8, {tag, "_arming"});
        cap_ready = 1'b0;
        cap_armed = 1'b1;
        wait_st(S_ARMED, 8, {tag, "_armed"});
    endtask

    task automatic to_triggered(input string tag);
        cap_triggered = 1'b1;
        wait_st(S_TRIG, 8, {tag, "_trig"});
        cap_triggered = 1'b0;
        cap_armed = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; stop = 1'b0; cap_ready = 1'b0; cap_armed = 1'b0;
        cap_triggered = 1'b0; cap_done = 1'b0; cap_overrun = 1'b0; dma_idle = 1'b0;
        repeat_count = 8'd1; timeout = 32'd0; cap_trig_pos = 24'h0;
        repeat (3) tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_arm", 32'(cap_arm), 0);
        chk("rst_abort", 32'(cap_abort), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_cnt", 32'(done_count), 0);
        chk("rst_errs", 32'({err_overrun, err_timeout}), 0);
        resetn = 1'b1;
        tick();
        // single shot with exact synchroniser latency
        irq_base = irq_cnt;
        pulse_start();
        chk("s1_wrdy", 32'(state), 32'(S_WRDY));
        chk("s1_busy", 32'(busy), 1);
        cap_ready = 1'b1;
        repeat (2) tick();
        chk("s1_rdy_lat", 32'(state), 32'(S_WRDY));
        tick();
        chk("s1_arming", 32'(state), 32'(S_ARMING));
        chk("s1_arm_on", 32'(cap_arm), 1);
        cap_ready = 1'b0;
        repeat (4) tick();
        chk("s1_arm_held", 32'(cap_arm), 1);
        cap_armed = 1'b1;
        repeat (2) tick();
        chk("s1_arm_lat", 32'({state, cap_arm}), 32'({S_ARMING, 1'b1}));
        tick();
        chk("s1_armed", 32'(state), 32'(S_ARMED));
        chk("s1_arm_off", 32'(cap_arm), 0);
        to_triggered("s1");
        cap_trig_pos = 24'h000123;
        cap_done = 1'b1;
        repeat (2) tick();
        chk("s1_done_lat", 32'(state), 32'(S_TRIG));
        tick();
        chk("s1_drain", 32'(state), 32'(S_DRAIN));
        chk("s1_cnt", 32'(done_count), 1);
        chk("s1_pos", 32'(trig_pos), 32'h123);
        cap_done = 1'b0;
        repeat (3) tick();
        chk("s1_drain_hold", 32'(state), 32'(S_DRAIN));
        dma_idle = 1'b1;
        tick();
        chk("s1_idle", 32'(state), 32'(S_IDLE));
        chk("s1_irq", 32'(irq), 1);
        chk("s1_busy_off", 32'(busy), 0);
        tick();
        chk("s1_irq_pulse", 32'(irq), 0);
        chk("s1_irq_cnt", 32'(irq_cnt - irq_base), 1);
        // three shots, one irq at the end
        repeat_count = 8'd3;
        irq_base = irq_cnt;
        pulse_start();
        chk("m_cnt_clr", 32'(done_count), 0);
        for (int k = 1; k <= 3; k++) begin
            to_armed("m");
            to_triggered("m");
            cap_trig_pos = 24'h00A000 + 24'(k);
            cap_done = 1'b1;
            wait_st(S_DRAIN, 8, "m_drain");
            cap_done = 1'b0;
            chk("m_cnt", 32'(done_count), 32'(k));
            chk("m_pos", 32'(trig_pos), 32'h00A000 + 32'(k));
            if (k < 3) wait_st(S_WRDY, 3, "m_next");
        end
        wait_st(S_IDLE, 3, "m_idle");
        tick();
        chk("m_irq_cnt", 32'(irq_cnt - irq_base), 1);
        // watchdog expiry after 100 armed cycles
        repeat_count = 8'd1;
        timeout = 32'd100;
        irq_base = irq_cnt;
        pulse_start();
        to_armed("wd");
        repeat (99) tick();
        chk("wd_cyc100", 32'({state, err_timeout}), 32'({S_ARMED, 1'b0}));
        tick();
        chk("wd_abort", 32'(state), 32'(S_ABORT));
        chk("wd_err", 32'(err_timeout), 1);
        chk("wd_arm_abort", 32'({cap_arm, cap_abort}), 32'b01);
        repeat (5) tick();
        chk("wd_hold", 32'(state), 32'(S_ABORT));
        cap_armed = 1'b0;
        repeat (2) tick();
        chk("wd_hold_lat", 32'(state), 32'(S_ABORT));
        tick();
        chk("wd_idle", 32'(state), 32'(S_IDLE));
        chk("wd_irq", 32'(irq), 1);
        chk("wd_abort_off", 32'(cap_abort), 0);
        chk("wd_err_hold", 32'(err_timeout), 1);
        tick();
        chk("wd_irq_cnt", 32'(irq_cnt - irq_base), 1);
        // overrun while triggered
        timeout = 32'd0;
        pulse_start();
        chk("ov_err_clr", 32'(err_timeout), 0);
        to_armed("ov");
        to_triggered("ov");
        cap_overrun = 1'b1;
        tick();
        cap_overrun = 1'b0;
        tick();
        chk("ov_lat", 32'(state), 32'(S_TRIG));
        tick();
        chk("ov_abort", 32'(state), 32'(S_ABORT));
        chk("ov_err", 32'(err_overrun), 1);
        chk("ov_cnt", 32'(done_count), 0);
        irq_base = irq_cnt;
        tick();
        chk("ov_idle", 32'({state, irq}), 32'({S_IDLE, 1'b1}));
        tick();
        chk("ov_irq_cnt", 32'(irq_cnt - irq_base), 1);
        // stop while draining with dma busy
        dma_idle = 1'b0;
        pulse_start();
        chk("st_err_clr", 32'(err_overrun), 0);
        to_armed("st");
        to_triggered("st");
        cap_done = 1'b1;
        wait_st(S_DRAIN, 8, "st_drain");
        cap_done = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("st_abort", 32'({state, cap_abort}), 32'({S_ABORT, 1'b1}));
        repeat (4) tick();
        chk("st_hold", 32'(state), 32'(S_ABORT));
        irq_base = irq_cnt;
        dma_idle = 1'b1;
        tick();
        chk("st_idle", 32'({state, irq}), 32'({S_IDLE, 1'b1}));
        tick();
        chk("st_irq_cnt", 32'(irq_cnt - irq_base), 1);
        // asynchronous reset while armed
        pulse_start();
        to_armed("ar");
        chk("ar_busy", 32'(busy), 1);
        #2 resetn = 1'b0;
        #1;
        chk("ar_state", 32'(state), 0);
        chk("ar_busy0", 32'(busy), 0);
        chk("ar_pos", 32'(trig_pos), 0);
        chk("ar_cnt", 32'(done_count), 0);
        chk("ar_flags", 32'({cap_arm, cap_abort, irq, err_overrun, err_timeout}), 0);
        cap_armed = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        // start and stop together leave the sequencer idle
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("ss_state", 32'({state, busy}), 0);
        repeat (4) tick();
        chk("ss_still_idle", 32'(state), 0);
        chk("excl", 32'(excl_cnt), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
